// File: rtl/flex_counter_ud.sv
// Up/down counter with programmable upper terminal value, wrap or saturate mode,
// and registered terminal flag and wrap/saturation pulse.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_event;
  logic                    next_flag;
  logic                    cnt_active;

  assign cnt_active = count_enable && (rollover_val != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    next_count = count_out;
    next_event = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (cnt_active) begin
      if (!count_down) begin
        if (count_out < rollover_val) begin
          next_count = count_out + ONE;
        end else begin
          next_count = sat_mode ? rollover_val : ONE;
          next_event = 1'b1;
        end
      end else begin
        // Values above rollover_val still step down toward 1.
        if (count_out > ONE) begin
          next_count = count_out - ONE;
        end else begin
          next_count = sat_mode ? count_out : rollover_val;
          next_event = 1'b1;
        end
      end
    end
  end

  // Flag is derived from the next count so it lines up with count_out.
  assign next_flag = (next_count == rollover_val) && (rollover_val != '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
      wrap_pulse    <= next_event;
    end
  end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Self-checking bench for flex_counter_ud: directed scenarios plus randomized
// traffic, all compared against an arithmetic reference model.
module tb_flex_counter_ud;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, clear, load, count_enable, count_down, sat_mode;
  logic [W-1:0] load_val, rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag, wrap_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt  = 0;
  int m_flag = 0;
  int m_wrap = 0;

  flex_counter_ud #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_down   (count_down),
    .sat_mode     (sat_mode),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over the counting rules.
  task automatic model_edge();
    int rv;
    int c;
    int evt;
    rv  = int'(rollover_val);
    c   = m_cnt;
    evt = 0;
    if (rst || clear) begin
      c = 0;
    end else if (load) begin
      c = int'(load_val);
    end else if (count_enable && rv != 0) begin
      if (!count_down) begin
        if (c < rv) c = c + 1;
        else begin c = sat_mode ? rv : 1; evt = 1; end
      end else begin
        if (c > 1) c = c - 1;
        else begin c = sat_mode ? c : rv; evt = 1; end
      end
    end
    m_cnt  = c;
    m_flag = (!rst && rv != 0 && c == rv) ? 1 : 0;
    m_wrap = rst ? 0 : evt;
  endtask

  // One clock: update model from current inputs, then sample DUT 1 time unit after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".cnt"},  32'(count_out),     32'(m_cnt));
    check({tag, ".flag"}, 32'(rollover_flag), 32'(m_flag));
    check({tag, ".wrap"}, 32'(wrap_pulse),    32'(m_wrap));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_inputs();
    load = 1'b1; load_val = v;
    step("load");
    load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq_up   [7];
    logic [W-1:0] seq_dsat [4];
    logic [W-1:0] seq_dwr  [3];

    rst = 1'b1; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    count_down = 1'b0; sat_mode = 1'b0; load_val = '0; rollover_val = 4'd5;
    #1;

    // Reset state
    step("reset0");
    step("reset1");
    check("reset.cnt_lit",  32'(count_out), 32'd0);
    check("reset.flag_lit", 32'(rollover_flag), 32'd0);
    check("reset.wrap_lit", 32'(wrap_pulse), 32'd0);

    // Up wrap, rollover 5
    seq_up = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
    idle_inputs();
    rollover_val = 4'd5; sat_mode = 1'b0; count_down = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step("upwrap");
      check("upwrap.seq",  32'(count_out), 32'(seq_up[i]));
      check("upwrap.flag_lit", 32'(rollover_flag), (i == 4) ? 32'd1 : 32'd0);
      check("upwrap.wrap_lit", 32'(wrap_pulse),    (i == 5) ? 32'd1 : 32'd0);
    end

    // Down saturate from 3
    seq_dsat = '{4'd2, 4'd1, 4'd1, 4'd1};
    do_load(4'd3);
    count_down = 1'b1; sat_mode = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("dnsat");
      check("dnsat.seq", 32'(count_out), 32'(seq_dsat[i]));
      check("dnsat.wrap_lit", 32'(wrap_pulse), (i >= 2) ? 32'd1 : 32'd0);
    end

    // Down wrap, rollover 9
    seq_dwr = '{4'd1, 4'd9, 4'd8};
    rollover_val = 4'd9;
    do_load(4'd2);
    count_down = 1'b1; sat_mode = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("dnwrap");
      check("dnwrap.seq", 32'(count_out), 32'(seq_dwr[i]));
      check("dnwrap.flag_lit", 32'(rollover_flag), (i == 1) ? 32'd1 : 32'd0);
    end

    // Priority: clear beats load and enable, load beats enable
    do_load(4'd4);
    clear = 1'b1; load = 1'b1; load_val = 4'd7; count_enable = 1'b1; count_down = 1'b0;
    step("prio_clr");
    check("prio_clr.lit", 32'(count_out), 32'd0);
    clear = 1'b0;
    step("prio_ld");
    check("prio_ld.lit", 32'(count_out), 32'd7);
    idle_inputs();

    // Out-of-range count with rollover lowered
    rollover_val = 4'd6;
    do_load(4'd12);
    count_enable = 1'b1; count_down = 1'b0; sat_mode = 1'b0;
    step("oor_wrap");
    check("oor_wrap.lit", 32'(count_out), 32'd1);
    check("oor_wrap.pulse_lit", 32'(wrap_pulse), 32'd1);
    do_load(4'd12);
    count_enable = 1'b1; sat_mode = 1'b1;
    step("oor_sat");
    check("oor_sat.lit", 32'(count_out), 32'd6);
    check("oor_sat.flag_lit", 32'(rollover_flag), 32'd1);
    do_load(4'd12);
    count_enable = 1'b1; count_down = 1'b1;
    step("oor_down");
    check("oor_down.lit", 32'(count_out), 32'd11);

    // Reset mid-count, then all-ones rollover
    do_load(4'd3);
    rst = 1'b1; count_enable = 1'b1; count_down = 1'b0;
    step("midrst");
    check("midrst.lit", 32'({count_out, rollover_flag, wrap_pulse}), 32'd0);
    rst = 1'b0; rollover_val = 4'd15; sat_mode = 1'b0; count_enable = 1'b1; count_down = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step("allones");
      check("allones.seq", 32'(count_out), (i < 15) ? 32'(i + 1) : 32'd1);
      check("allones.noX", 32'($isunknown({count_out, rollover_flag, wrap_pulse})), 32'd0);
    end

    // Disabled counter (rollover 0)
    do_load(4'd5);
    rollover_val = 4'd0; count_enable = 1'b1;
    step("dis0");
    step("dis1");
    check("dis.cnt_lit", 32'(count_out), 32'd5);
    check("dis.flag_lit", 32'(rollover_flag), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      clear        = ($urandom_range(0, 24) == 0);
      load         = ($urandom_range(0, 9) == 0);
      load_val     = W'($urandom);
      count_enable = ($urandom_range(0, 3) != 0);
      count_down   = $urandom_range(0, 1) == 1;
      sat_mode     = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) rollover_val = W'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
